// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl shared constants
// FSM states, owner codes, I/O region decode
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  typedef enum logic {
    OWN_IC  = 1'b0,
    OWN_LSB = 1'b1
  } mc_own_e;

  localparam int         IO_HI  = 17;
  localparam int         IO_LO  = 16;
  localparam logic [1:0] IO_SEL = 2'b11;

endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: 2-way round-robin grant
// gnt_o[0] = ICache, gnt_o[1] = LSB
module mem_rr_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_i,
  input  logic       req_ic_i,
  input  logic       req_lsb_i,
  output logic [1:0] gnt_o
);

  mc_own_e last_q;
  mc_own_e last_d;

  // pick the requester that did not win last time on a tie
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (req_ic_i && req_lsb_i) begin
        gnt_o = (last_q == OWN_IC) ? 2'b10 : 2'b01;
      end else if (req_ic_i) begin
        gnt_o = 2'b01;
      end else if (req_lsb_i) begin
        gnt_o = 2'b10;
      end
      if (gnt_o[0]) last_d = OWN_IC;
      else if (gnt_o[1]) last_d = OWN_LSB;
    end
  end

  // pointer remembers the last winner
  always_ff @(posedge clk_in) begin
    if (rst_in) last_q <= OWN_IC;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM port shared by ICache and LSB
// reads are pipelined one byte/cycle, writes one byte/cycle
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    ic_req,
  input  logic [31:0]             ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_data,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [31:0]             lsb_addr,
  input  logic [2:0]              lsb_len,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int LW = LINE_BYTES * 8;
  localparam int CW = $clog2(LINE_BYTES) + 1;

  mc_state_e      state_q;
  mc_own_e        own_q;
  logic [31:0]    base_q;
  logic [CW-1:0]  len_q;
  logic [31:0]    wdata_q;
  logic [CW-1:0]  iss_q;
  logic [CW-1:0]  rcv_q;
  logic           pv_q;
  logic [LW-1:0]  buf_q;
  logic [LW-1:0]  ic_data_q;
  logic [31:0]    lsb_rdata_q;
  logic           ic_done_q;
  logic           lsb_done_q;

  logic [CW-1:0]  cur;
  logic [31:0]    addr_cur;
  logic           issuing;
  logic           cap;
  logic           last_cap;
  logic           io_hold;
  logic [1:0]     gnt;
  logic [LW-1:0]  buf_nx;

  // a frozen read re-presents the next byte still owed
  assign cur      = (state_q == MC_READ && !rdy_in) ? rcv_q : iss_q;
  assign addr_cur = base_q + 32'(cur);
  assign issuing  = cur < len_q;
  assign cap      = (state_q == MC_READ) && rdy_in && pv_q;
  assign last_cap = cap && (rcv_q == len_q - CW'(1));
  assign io_hold  = (state_q == MC_WRITE) && io_buffer_full
                 && (addr_cur[IO_HI:IO_LO] == IO_SEL);

  assign mem_a    = (state_q != MC_IDLE && issuing) ? addr_cur : '0;
  assign mem_wr   = (state_q == MC_WRITE) && rdy_in && !io_hold;
  assign mem_dout = (state_q == MC_WRITE)
                  ? wdata_q[{iss_q[1:0], 3'b000} +: 8] : 8'h00;

  assign ic_done   = ic_done_q;
  assign ic_data   = ic_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

  // a requester is not re-granted in its own done cycle
  mem_rr_arbiter u_arb (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_i      ((state_q == MC_IDLE) && rdy_in && !rob_clear),
    .req_ic_i  (ic_req && !ic_done_q),
    .req_lsb_i (lsb_req && !lsb_done_q),
    .gnt_o     (gnt)
  );

  // merge the arriving byte into the assembly buffer
  always_comb begin
    buf_nx = buf_q;
    if (cap) buf_nx[{rcv_q[CW-2:0], 3'b000} +: 8] = mem_din;
  end

  // access sequencer
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= MC_IDLE;
      own_q       <= OWN_IC;
      base_q      <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      iss_q       <= '0;
      rcv_q       <= '0;
      pv_q        <= 1'b0;
      buf_q       <= '0;
      ic_data_q   <= '0;
      lsb_rdata_q <= '0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
    end else if (rdy_in) begin
      ic_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      unique case (state_q)
        MC_IDLE: begin
          if (gnt != 2'b00) begin
            own_q   <= gnt[1] ? OWN_LSB : OWN_IC;
            base_q  <= gnt[1] ? lsb_addr : ic_addr;
            len_q   <= gnt[1] ? CW'(lsb_len) : CW'(LINE_BYTES);
            wdata_q <= lsb_wdata;
            iss_q   <= '0;
            rcv_q   <= '0;
            pv_q    <= 1'b0;
            buf_q   <= '0;
            state_q <= (gnt[1] && lsb_wr) ? MC_WRITE : MC_READ;
          end
        end
        MC_READ: begin
          if (rob_clear) begin
            pv_q    <= 1'b0;
            state_q <= MC_IDLE;
          end else begin
            pv_q <= issuing;
            if (issuing) iss_q <= iss_q + CW'(1);
            if (cap) begin
              buf_q <= buf_nx;
              rcv_q <= rcv_q + CW'(1);
            end
            if (last_cap) begin
              state_q <= MC_IDLE;
              if (own_q == OWN_IC) begin
                ic_data_q <= buf_nx;
                ic_done_q <= 1'b1;
              end else begin
                lsb_rdata_q <= buf_nx[31:0];
                lsb_done_q  <= 1'b1;
              end
            end
          end
        end
        MC_WRITE: begin
          if (mem_wr) begin
            iss_q <= iss_q + CW'(1);
            if (iss_q == len_q - CW'(1)) begin
              state_q    <= MC_IDLE;
              lsb_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= MC_IDLE;
      endcase
    end else if (state_q == MC_READ) begin
      iss_q <= rcv_q + CW'(1);
      pv_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl
// RAM model answers one cycle after the address
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_clear = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [2:0]  lsb_len = '0;
  logic [31:0] lsb_wdata = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  typedef struct {
    bit          lsb;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ram [int unsigned];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          t;
  logic [31:0] last_lsb;
  logic [31:0] last_ic;

  mem_ctrl #(.LINE_BYTES(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rob_clear      (rob_clear),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_done        (ic_done),
    .ic_data        (ic_data),
    .lsb_req        (lsb_req),
    .lsb_wr         (lsb_wr),
    .lsb_addr       (lsb_addr),
    .lsb_len        (lsb_len),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    logic [7:0] v;
    v = ram.exists(a) ? ram[a] : (a[7:0] ^ 8'hA5);
    return v;
  endfunction

  function automatic logic [31:0] ld(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ram_rd(a + 32'(i));
    return r;
  endfunction

  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input bit lsb, input logic [31:0] d, input int c);
    exp_t e;
    e.lsb  = lsb;
    e.data = d;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (lsb_done) lsb_req = 1'b0;
    if (ic_done) ic_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ic_req || lsb_req) && n < 200) begin
      tick();
      n++;
    end
    check("req_timeout", 32'(ic_req | lsb_req), 0);
    tick();
  endtask

  task automatic lsb_go(input logic wr, input logic [31:0] a,
                        input logic [2:0] n, input logic [31:0] d);
    lsb_req   = 1'b1;
    lsb_wr    = wr;
    lsb_addr  = a;
    lsb_len   = n;
    lsb_wdata = d;
  endtask

  // scoreboard: every done pulse pops one expectation
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in && (ic_done || lsb_done)) begin
      check("done_excl", 32'(ic_done & lsb_done), 0);
      if (sbq.size() == 0) begin
        check("done_unexp", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("done_owner", 32'(lsb_done), 32'(e.lsb));
        check("done_cycle", cyc, e.cyc);
        check("done_data", e.lsb ? lsb_rdata : ic_data, e.data);
      end
    end
    if (!rst_in && !rdy_in) check("stall_nowr", 32'(mem_wr), 0);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    ram[32'h100] = 8'h11;
    ram[32'h101] = 8'h22;
    ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44;

    repeat (3) tick();
    check("rst_ic_done", 32'(ic_done), 0);
    check("rst_lsb_done", 32'(lsb_done), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", 32'(mem_dout), 0);
    check("rst_ic_data", ic_data, 0);
    check("rst_lsb_rdata", lsb_rdata, 0);
    rst_in = 1'b0;

    // tie after reset: LSB, then ICache, then the re-raised LSB
    t = cyc;
    ic_req  = 1'b1;
    ic_addr = 32'h200;
    lsb_go(1'b0, 32'h104, 3'd2, 0);
    last_ic = ld(32'h200, 4);
    push(1'b1, ld(32'h104, 2), t + 4);
    push(1'b0, last_ic, t + 10);
    push(1'b1, ld(32'h108, 1), t + 13);
    last_lsb = ld(32'h108, 1);
    while (cyc < t + 4) tick();
    lsb_go(1'b0, 32'h108, 3'd1, 0);
    wait_idle();

    // plain 4-byte load with address trace
    t = cyc;
    lsb_go(1'b0, 32'h100, 3'd4, 0);
    push(1'b1, 32'h44332211, t + 6);
    last_lsb = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ld_mem_a", mem_a, 32'h100 + 32'(i));
    end
    wait_idle();

    // I/O store held while the UART buffer is full
    t = cyc;
    lsb_go(1'b1, 32'h30000, 3'd1, 32'h41);
    io_buffer_full = 1'b1;
    push(1'b1, last_lsb, t + 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("io_hold_wr", 32'(mem_wr), 0);
    end
    tick();
    io_buffer_full = 1'b0;
    #1;
    check("io_wr", 32'(mem_wr), 1);
    check("io_dout", 32'(mem_dout), 32'h41);
    check("io_addr", mem_a, 32'h30000);
    wait_idle();
    check("io_ram", 32'(ram_rd(32'h30000)), 32'h41);

    // flush aborts a refill; pending LSB load goes next
    t = cyc;
    ic_req  = 1'b1;
    ic_addr = 32'h240;
    tick();
    lsb_go(1'b0, 32'h10C, 3'd1, 0);
    tick();
    tick();
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    ic_req    = 1'b0;
    push(1'b1, ld(32'h10C, 1), t + 7);
    last_lsb = ld(32'h10C, 1);
    check("flush_no_done", 32'(ic_done), 0);
    check("flush_ic_hold", ic_data, last_ic);
    tick();
    check("flush_next_a", mem_a, 32'h10C);
    wait_idle();

    // committed store ignores a flush
    t = cyc;
    lsb_go(1'b1, 32'h80, 3'd2, 32'h0000BEEF);
    push(1'b1, last_lsb, t + 3);
    tick();
    rob_clear = 1'b1;
    #1;
    check("st_wr0", 32'(mem_wr), 1);
    check("st_dout0", 32'(mem_dout), 32'hEF);
    check("st_a0", mem_a, 32'h80);
    tick();
    rob_clear = 1'b0;
    #1;
    check("st_wr1", 32'(mem_wr), 1);
    check("st_dout1", 32'(mem_dout), 32'hBE);
    check("st_a1", mem_a, 32'h81);
    wait_idle();
    check("st_ram", 32'({ram_rd(32'h81), ram_rd(32'h80)}), 32'hBEEF);

    // store with one frozen cycle
    t = cyc;
    lsb_go(1'b1, 32'h90, 3'd1, 32'h5C);
    push(1'b1, last_lsb, t + 3);
    tick();
    rdy_in = 1'b0;
    #1;
    check("frz_wr", 32'(mem_wr), 0);
    tick();
    rdy_in = 1'b1;
    #1;
    check("frz_resume_wr", 32'(mem_wr), 1);
    check("frz_dout", 32'(mem_dout), 32'h5C);
    wait_idle();
    check("frz_ram", 32'(ram_rd(32'h90)), 32'h5C);

    // load with two frozen cycles mid-transfer
    t = cyc;
    lsb_go(1'b0, 32'h100, 3'd4, 0);
    push(1'b1, 32'h44332211, t + 8);
    tick();
    tick();
    tick();
    rdy_in = 1'b0;
    tick();
    tick();
    rdy_in = 1'b1;
    wait_idle();

    check("sb_drain", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
